// File: rtl/program_loader.sv
// Stream-fed program loader: takes a word count header plus program words, writes them into
// memory through a registered port and releases the CPU once loaded. Define LOADER_CHECKSUM_EN
// to require a trailing two's-complement checksum word before release.
module program_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned CAP_WORDS = (1 << ADDR_WIDTH) - BASE_ADDR;
    localparam logic [DATA_WIDTH:0] CAPACITY = (DATA_WIDTH + 1)'(CAP_WORDS);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_HEADER = 3'd0,
        S_LOAD   = 3'd1,
        S_CHECK  = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;
    localparam state_t S_FINISH = S_CHECK;
`else
    typedef enum logic [2:0] {
        S_HEADER = 3'd0,
        S_LOAD   = 3'd1,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;
    localparam state_t S_FINISH = S_DONE;
`endif

    state_t                state_q, state_d;
    logic                  run_q, run_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  done_q, done_d;
    logic                  cpu_reset_q, cpu_reset_d;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

    logic ready;
    logic accept;

    // run_q holds the stream off until the first edge after reset release.
    always_comb begin
        ready = 1'b0;
        if (run_q) begin
            case (state_q)
                S_HEADER, S_LOAD: ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                S_CHECK:          ready = 1'b1;
`endif
                default:          ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid & ready;

    always_comb begin
        state_d     = state_q;
        run_d       = 1'b1;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = (state_q == S_DONE);
        cpu_reset_d = done_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        if (accept) begin
            case (state_q)
                S_HEADER: begin
`ifdef LOADER_CHECKSUM_EN
                    sum_d = in_data;
`endif
                    if ({1'b0, in_data} > CAPACITY) begin
                        state_d = S_ERROR;
                    end else if (in_data == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d     = S_LOAD;
                        remaining_d = in_data[ADDR_WIDTH:0];
                        addr_d      = ADDR_WIDTH'(BASE_ADDR);
                    end
                end
                S_LOAD: begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d       = sum_q + in_data;
`endif
                    if (remaining_q == 1) begin
                        state_d = S_FINISH;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    state_d = ((sum_q + in_data) == '0) ? S_DONE : S_ERROR;
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_HEADER;
            run_q       <= 1'b0;
            remaining_q <= '0;
            addr_q      <= '0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            cpu_reset_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            cpu_reset_q <= cpu_reset_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign in_ready  = ready;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign cpu_reset = cpu_reset_q;
    assign error     = (state_q == S_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: streams images with random gaps and compares writes,
// completion timing and status against a stream-level reference model.
module tb_program_loader;

    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int BASE = 0;
    localparam int CAP  = (1 << AW) - BASE;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;

    program_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int            a;
        logic [DW-1:0] d;
        int            c;
    } wr_t;

    wr_t  wr_q[$];
    int   done_rise_q[$];
    int   cpu_rise_q[$];
    int   err_rise_q[$];
    logic done_prev = 1'b0;
    logic cpu_prev  = 1'b0;
    logic err_prev  = 1'b0;

    always @(negedge clock) begin
        if (mem_write) wr_q.push_back('{a: int'(mem_addr), d: mem_wdata, c: cyc});
        if (done && !done_prev)     done_rise_q.push_back(cyc);
        if (cpu_reset && !cpu_prev) cpu_rise_q.push_back(cyc);
        if (error && !err_prev)     err_rise_q.push_back(cyc);
        done_prev <= done;
        cpu_prev  <= cpu_reset;
        err_prev  <= error;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_mem_write"}, 64'(mem_write), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b1;
        #1;
        check("ready_at_release", 64'(in_ready), 64'd0);
        @(negedge clock);
        check("ready_after_edge", 64'(in_ready), 64'd1);
    endtask

    // Presents one word from a negedge and returns on the negedge after it is taken.
    task automatic send_word(input logic [DW-1:0] w, output int acc_cyc);
        bit acc;
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        acc_cyc  = -1;
        for (int t = 0; t < 50; t++) begin
            acc = in_ready;
            @(posedge clock);
            #1;
            if (acc) begin
                acc_cyc = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        @(negedge clock);
    endtask

    task automatic gap(input int mode);
        int g;
        g = (mode == 0) ? 0 : (mode == 1) ? 1 : ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
        if (g > 0) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            repeat (g) @(negedge clock);
        end
    endtask

    // seed_val != 0 gives data words seed_val, seed_val+1, ...; otherwise random.
    task automatic run_trial(input logic [DW-1:0] n, input int gap_mode, input bit cs_good,
                             input logic [DW-1:0] seed_val);
        logic [DW-1:0] stream[$];
        int            acc_c[$];
        logic [DW-1:0] sum;
        int            w0, d0, c0, e0, nw, a;
        bit            exp_err;
        int            last_acc;

        w0 = wr_q.size(); d0 = done_rise_q.size();
        c0 = cpu_rise_q.size(); e0 = err_rise_q.size();

        exp_err = (longint'(n) > longint'(CAP));
        nw = exp_err ? 0 : int'(n);
        stream.push_back(n);
        for (int i = 0; i < nw; i++)
            stream.push_back(seed_val != '0 ? seed_val + DW'(i) : DW'($urandom));
`ifdef LOADER_CHECKSUM_EN
        if (!exp_err) begin
            sum = '0;
            foreach (stream[i]) sum = sum + stream[i];
            stream.push_back(cs_good ? -sum : -sum + DW'($urandom_range(1, 9)));
            exp_err = !cs_good;
        end
`else
        sum = '0;
`endif

        last_acc = -1;
        foreach (stream[i]) begin
            if (i > 0) gap(gap_mode);
            send_word(stream[i], a);
            acc_c.push_back(a);
            last_acc = a;
        end
        in_data = $urandom;
        repeat (3) @(negedge clock);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);

        check("write_count", 64'(wr_q.size() - w0), 64'(nw));
        for (int i = 0; i < nw && (w0 + i) < wr_q.size(); i++) begin
            check("write_addr", 64'(wr_q[w0+i].a), 64'(BASE + i));
            check("write_data", 64'(wr_q[w0+i].d), 64'(stream[i+1]));
            check("write_cycle", 64'(wr_q[w0+i].c), 64'(acc_c[i+1]));
        end
        check("done_final", 64'(done), 64'(!exp_err));
        check("error_final", 64'(error), 64'(exp_err));
        check("cpu_reset_final", 64'(cpu_reset), 64'(!exp_err));
        check("in_ready_final", 64'(in_ready), 64'd0);
        check("done_rises", 64'(done_rise_q.size() - d0), 64'(!exp_err));
        check("cpu_rises", 64'(cpu_rise_q.size() - c0), 64'(!exp_err));
        check("err_rises", 64'(err_rise_q.size() - e0), 64'(exp_err));
        if (!exp_err && done_rise_q.size() > d0 && cpu_rise_q.size() > c0) begin
            check("done_cycle", 64'(done_rise_q[d0]), 64'(last_acc + 1));
            check("cpu_cycle", 64'(cpu_rise_q[c0]), 64'(last_acc + 2));
        end
        if (exp_err && err_rise_q.size() > e0)
            check("error_cycle", 64'(err_rise_q[e0]), 64'(last_acc));
        $display("trial header=%0d gaps=%0d writes=%0d done=%0b error=%0b miscompares=%0d",
                 n, gap_mode, wr_q.size() - w0, done, error, n_err);
    endtask

    initial begin
        int a;
        do_reset();
        run_trial(32'd3, 0, 1'b1, 32'hA0);
        do_reset();
        run_trial(32'd2, 1, 1'b1, 32'd11);
        do_reset();
        run_trial(32'd1025, 0, 1'b1, 32'd0);
        do_reset();
        run_trial(32'd0, 0, 1'b1, 32'd0);
        do_reset();
        run_trial(32'hFFFF_FFFF, 2, 1'b1, 32'd0);

        do_reset();
        send_word(32'd4, a);
        send_word(32'h1234, a);
        send_word(32'h5678, a);
        reset = 1'b0;
        #1;
        check_idle_outputs("midload");
        do_reset();
        run_trial(32'd1, 0, 1'b1, 32'd5);

        do_reset();
        run_trial(DW'(CAP), 0, 1'b1, 32'd0);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        run_trial(32'd2, 0, 1'b1, 32'd1);
        do_reset();
        run_trial(32'd2, 0, 1'b0, 32'd1);
`endif

        for (int t = 0; t < 14; t++) begin
            logic [DW-1:0] n;
            do_reset();
            if ($urandom_range(0, 5) == 0) n = DW'(CAP + 1 + int'($urandom_range(0, 5000)));
            else n = DW'($urandom_range(0, 9));
            run_trial(n, int'($urandom_range(0, 2)), $urandom_range(0, 3) != 0, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
